pc_redirect_ctrl: RTL and testbench



---
 rtl/pc_ctrl_pkg.sv | 21 ++
 rtl/npc_select.sv | 48 ++++
 rtl/pc_redirect_ctrl.sv | 157 +++++++++++++++
 tb/tb_pc_redirect_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg: types and constants shared by the fetch sequencing controller.
//   pc_state_e   : controller state (BOOT, RUN, DRAIN)
//   redir_src_e  : pipeline stage that produced a redirect (none, ID, EX)
//   DEFAULT_RESET_PC : first fetch address used when the top is not overridden
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } pc_state_e;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ID   = 2'd1,
    SRC_EX   = 2'd2
  } redir_src_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/npc_select.sv
// npc_select: combinational priority mux over the redirect sources.
//   branch_e/branch_target : taken branch from EX   (highest priority)
//   jalr_e/jalr_target     : JALR from EX
//   jal_d/jal_target       : JAL from ID            (lowest priority)
//   valid  : some redirect is requested this cycle
//   source : stage class of the winning redirect
//   target : winning target with bits [1:0] cleared
module npc_select
  import pc_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            branch_e,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jalr_e,
  input  logic [XLEN-1:0] jalr_target,
  input  logic            jal_d,
  input  logic [XLEN-1:0] jal_target,
  output logic            valid,
  output redir_src_e      source,
  output logic [XLEN-1:0] target
);

  logic [XLEN-1:0] raw_target;

  // EX redirects come from older instructions than the one in ID, so they win.
  always_comb begin
    valid      = 1'b0;
    source     = SRC_NONE;
    raw_target = '0;
    if (branch_e) begin
      valid      = 1'b1;
      source     = SRC_EX;
      raw_target = branch_target;
    end else if (jalr_e) begin
      valid      = 1'b1;
      source     = SRC_EX;
      raw_target = jalr_target;
    end else if (jal_d) begin
      valid      = 1'b1;
      source     = SRC_ID;
      raw_target = jal_target;
    end
  end

  assign target = {raw_target[XLEN-1:2], 2'b00};

endmodule

// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: fetch-stage PC sequencer.
//   Owns the PC register, applies redirects from EX/ID, runs the instruction
//   memory request, holds a redirect that arrives while a fetch is still
//   outstanding, and raises the IF/ID and ID/EX flushes a redirect needs.
// Ports:
//   CPU_CLK, CPU_RST_N           : clock, asynchronous active-low reset
//   BranchE/BranchTarget         : taken branch resolved in EX
//   JalrE/JalrTarget             : JALR resolved in EX
//   JalD/JalTarget               : JAL decoded in ID
//   StallF                       : hazard-unit fetch stall
//   ImemReq/ImemAddr/ImemReady   : instruction memory request port
//   PCF                          : current fetch PC
//   FetchValid                   : word entering IF/ID is valid
//   FlushD/FlushE                : flush IF/ID and ID/EX
//   RedirectPend                 : a latched redirect waits for the fetch to drain
//   dbg_state                    : current controller state, for observation
//
// Memory handshake: ImemReq is a request-valid that stays high with ImemAddr
// stable until ImemReady is seen high in the same cycle; that cycle completes
// the fetch and the address may change on the following edge.
module pc_redirect_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int                XLEN     = 32,
  parameter logic [XLEN-1:0]   RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic            CPU_CLK,
  input  logic            CPU_RST_N,
  input  logic            BranchE,
  input  logic [XLEN-1:0] BranchTarget,
  input  logic            JalrE,
  input  logic [XLEN-1:0] JalrTarget,
  input  logic            JalD,
  input  logic [XLEN-1:0] JalTarget,
  input  logic            StallF,
  input  logic            ImemReady,
  output logic            ImemReq,
  output logic [XLEN-1:0] ImemAddr,
  output logic [XLEN-1:0] PCF,
  output logic            FetchValid,
  output logic            FlushD,
  output logic            FlushE,
  output logic            RedirectPend,
  output pc_state_e       dbg_state
);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pcf_q, pcf_d;
  logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
  redir_src_e      pend_src_q, pend_src_d;

  logic            sel_valid;
  redir_src_e      sel_src;
  logic [XLEN-1:0] sel_tgt;
  logic            ex_replaces_id;

  npc_select #(.XLEN(XLEN)) u_npc_select (
    .branch_e      (BranchE),
    .branch_target (BranchTarget),
    .jalr_e        (JalrE),
    .jalr_target   (JalrTarget),
    .jal_d         (JalD),
    .jal_target    (JalTarget),
    .valid         (sel_valid),
    .source        (sel_src),
    .target        (sel_tgt)
  );

  // While draining, only an EX redirect may displace a pending ID redirect:
  // the EX instruction is older, so the JAL in ID is on a wrong path.
  assign ex_replaces_id = sel_valid && (sel_src == SRC_EX) && (pend_src_q == SRC_ID);

  always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
    if (!CPU_RST_N) begin
      state_q    <= BOOT;
      pcf_q      <= RESET_PC;
      pend_tgt_q <= '0;
      pend_src_q <= SRC_NONE;
    end else begin
      state_q    <= state_d;
      pcf_q      <= pcf_d;
      pend_tgt_q <= pend_tgt_d;
      pend_src_q <= pend_src_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pcf_d        = pcf_q;
    pend_tgt_d   = pend_tgt_q;
    pend_src_d   = pend_src_q;
    ImemReq      = 1'b0;
    FetchValid   = 1'b0;
    FlushD       = 1'b0;
    FlushE       = 1'b0;
    RedirectPend = 1'b0;

    unique case (state_q)
      BOOT: begin
        // Pipeline registers are still holding reset garbage: flush both.
        FlushD  = 1'b1;
        FlushE  = 1'b1;
        state_d = RUN;
      end

      RUN: begin
        ImemReq = 1'b1;
        if (sel_valid) begin
          // A redirect overrides StallF; the word fetched this cycle is dropped.
          FlushD = 1'b1;
          FlushE = (sel_src == SRC_EX);
          if (ImemReady) begin
            pcf_d = sel_tgt;
          end else begin
            // The memory is still working on PCF; keep the address stable
            // and remember where to go once it answers.
            pend_tgt_d = sel_tgt;
            pend_src_d = sel_src;
            state_d    = DRAIN;
          end
        end else begin
          FetchValid = ImemReady & ~StallF;
          if (ImemReady && !StallF) begin
            pcf_d = pcf_q + XLEN'(4);
          end
        end
      end

      DRAIN: begin
        ImemReq      = 1'b1;
        FlushD       = 1'b1;
        RedirectPend = 1'b1;
        if (ex_replaces_id) begin
          FlushE     = 1'b1;
          pend_tgt_d = sel_tgt;
          pend_src_d = SRC_EX;
        end
        if (ImemReady) begin
          // The returned word belongs to the abandoned path and is discarded.
          pcf_d      = ex_replaces_id ? sel_tgt : pend_tgt_q;
          pend_tgt_d = '0;
          pend_src_d = SRC_NONE;
          state_d    = RUN;
        end
      end

      default: begin
        state_d = BOOT;
      end
    endcase
  end

  assign PCF       = pcf_q;
  assign ImemAddr  = pcf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb_pc_redirect_ctrl: directed vectors for the fetch PC sequencer.
// Each driven cycle pushes its hand-computed expected outputs
// {ImemReq, FetchValid, FlushD, FlushE, RedirectPend, ImemAddr, PCF}
// into exp_q; a monitor on the falling edge pops and compares.
module tb_pc_redirect_ctrl;
  import pc_ctrl_pkg::*;

  localparam int XLEN = 32;
  localparam int W    = 5 + 2 * XLEN;

  logic            clk;
  logic            rst_n;
  logic            branch_e;
  logic [XLEN-1:0] branch_target;
  logic            jalr_e;
  logic [XLEN-1:0] jalr_target;
  logic            jal_d;
  logic [XLEN-1:0] jal_target;
  logic            stall_f;
  logic            imem_ready;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] pcf;
  logic            fetch_valid;
  logic            flush_d;
  logic            flush_e;
  logic            redirect_pend;
  pc_state_e       dbg_state;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           vectors;
  int           miscompares;

  pc_redirect_ctrl #(.XLEN(XLEN), .RESET_PC(32'h0000_0000)) dut (
    .CPU_CLK      (clk),
    .CPU_RST_N    (rst_n),
    .BranchE      (branch_e),
    .BranchTarget (branch_target),
    .JalrE        (jalr_e),
    .JalrTarget   (jalr_target),
    .JalD         (jal_d),
    .JalTarget    (jal_target),
    .StallF       (stall_f),
    .ImemReady    (imem_ready),
    .ImemReq      (imem_req),
    .ImemAddr     (imem_addr),
    .PCF          (pcf),
    .FetchValid   (fetch_valid),
    .FlushD       (flush_d),
    .FlushE       (flush_e),
    .RedirectPend (redirect_pend),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  function automatic logic [W-1:0] ev(input logic req, input logic fv, input logic fd,
                                      input logic fe, input logic rp, input logic [XLEN-1:0] pc);
    return {req, fv, fd, fe, rp, pc, pc};
  endfunction

  task automatic drive(input logic br, input logic [XLEN-1:0] bt,
                       input logic jr, input logic [XLEN-1:0] jrt,
                       input logic jd, input logic [XLEN-1:0] jt,
                       input logic st, input logic rdy);
    branch_e      = br;
    branch_target = bt;
    jalr_e        = jr;
    jalr_target   = jrt;
    jal_d         = jd;
    jal_target    = jt;
    stall_f       = st;
    imem_ready    = rdy;
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, rdy);
  endtask

  // Push this cycle's expectation, then advance to just after the next edge.
  task automatic cyc(input string nm, input logic [W-1:0] e);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] act;
    logic [W-1:0] e;
    string        nm;
    if (exp_q.size() != 0) begin
      e   = exp_q.pop_front();
      nm  = name_q.pop_front();
      act = {imem_req, fetch_valid, flush_d, flush_e, redirect_pend, imem_addr, pcf};
      vectors++;
      if (act !== e) begin
        miscompares++;
        $display("FAIL %s: got req=%b fv=%b fd=%b fe=%b rp=%b addr=%h pc=%h, expected req=%b fv=%b fd=%b fe=%b rp=%b addr=%h pc=%h",
                 nm, act[W-1], act[W-2], act[W-3], act[W-4], act[W-5], act[2*XLEN-1:XLEN], act[XLEN-1:0],
                 e[W-1], e[W-2], e[W-3], e[W-4], e[W-5], e[2*XLEN-1:XLEN], e[XLEN-1:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    idle(1'b1);
    @(posedge clk);
    #1;
    cyc("reset_hold", ev(0, 0, 1, 1, 0, 32'h0));

    // Release: one BOOT cycle, then sequential fetch from RESET_PC.
    rst_n = 1'b1;
    cyc("boot", ev(0, 0, 1, 1, 0, 32'h0));
    for (int i = 0; i < 64; i++) begin
      cyc($sformatf("seq_%0d", i), ev(1, 1, 0, 0, 0, 32'(i * 4)));
    end

    // Taken branch at 0x100, memory ready.
    drive(1'b1, 32'h200, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    cyc("branch_flush", ev(1, 0, 1, 1, 0, 32'h100));
    idle(1'b1);
    cyc("branch_target", ev(1, 1, 0, 0, 0, 32'h200));

    // JALR beats JAL; target 0x83 aligns to 0x80.
    drive(1'b0, '0, 1'b1, 32'h83, 1'b1, 32'h40, 1'b0, 1'b1);
    cyc("jalr_over_jal", ev(1, 0, 1, 1, 0, 32'h204));
    idle(1'b1);
    cyc("jalr_target", ev(1, 1, 0, 0, 0, 32'h80));

    // JAL while memory busy -> DRAIN; branch replaces it in the 2nd drain cycle.
    drive(1'b0, '0, 1'b0, '0, 1'b1, 32'h300, 1'b0, 1'b0);
    cyc("jal_busy", ev(1, 0, 1, 0, 0, 32'h84));
    idle(1'b0);
    cyc("drain_1", ev(1, 0, 1, 0, 1, 32'h84));
    drive(1'b1, 32'h500, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    cyc("drain_2_replace", ev(1, 0, 1, 1, 1, 32'h84));
    // A JAL during drain with an EX redirect pending is ignored.
    drive(1'b0, '0, 1'b0, '0, 1'b1, 32'h900, 1'b0, 1'b1);
    cyc("drain_ready", ev(1, 0, 1, 0, 1, 32'h84));
    idle(1'b1);
    cyc("drain_target", ev(1, 1, 0, 0, 0, 32'h500));

    // Get to 0x20 via a JAL, then stall.
    drive(1'b0, '0, 1'b0, '0, 1'b1, 32'h20, 1'b0, 1'b1);
    cyc("jal_ready", ev(1, 0, 1, 0, 0, 32'h504));
    drive(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
    cyc("stall_1", ev(1, 0, 0, 0, 0, 32'h20));
    cyc("stall_2", ev(1, 0, 0, 0, 0, 32'h20));
    drive(1'b1, 32'h600, 1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
    cyc("stall_branch", ev(1, 0, 1, 1, 0, 32'h20));
    idle(1'b1);
    cyc("stall_target", ev(1, 1, 0, 0, 0, 32'h600));
    idle(1'b0);
    cyc("not_ready_hold", ev(1, 0, 0, 0, 0, 32'h604));
    idle(1'b1);
    cyc("ready_again", ev(1, 1, 0, 0, 0, 32'h604));

    // Reset asserted mid-DRAIN drops the pending JALR.
    drive(1'b0, '0, 1'b1, 32'h707, 1'b0, '0, 1'b0, 1'b0);
    cyc("jalr_busy", ev(1, 0, 1, 1, 0, 32'h608));
    idle(1'b0);
    cyc("drain_pre_reset", ev(1, 0, 1, 0, 1, 32'h608));
    rst_n = 1'b0;
    idle(1'b1);
    cyc("async_reset", ev(0, 0, 1, 1, 0, 32'h0));
    rst_n = 1'b1;
    cyc("reboot", ev(0, 0, 1, 1, 0, 32'h0));
    cyc("refetch_0", ev(1, 1, 0, 0, 0, 32'h0));

    // Unaligned target masked, then PC wraps past the top of the address space.
    drive(1'b1, 32'hFFFF_FFFF, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    cyc("branch_top", ev(1, 0, 1, 1, 0, 32'h4));
    idle(1'b1);
    cyc("at_top", ev(1, 1, 0, 0, 0, 32'hFFFF_FFFC));
    cyc("wrapped", ev(1, 1, 0, 0, 0, 32'h0));

    // Let the monitor drain; anything left over is a miss.
    for (int i = 0; i < 5 && exp_q.size() != 0; i++) begin
      @(posedge clk);
    end
    if (exp_q.size() != 0) begin
      miscompares += exp_q.size();
      $display("FAIL drain_queue: got %0d unchecked entries, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
